ysyx_22050133_hazard_ctrl: RTL and testbench
============================================

Name: ysyx_22050133_hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RV64 core (IF/ID/EX/MEM/WB). It keeps a scoreboard of long-latency destination registers (loads, MUL/DIV) and generates stage stalls, flushes, and the has_hazard bubble request that the decode stage uses to zero its control bundles. It also serialises redirects (branch/jump/ecall/mret) against memory back-pressure and keeps saturating stall counters for performance analysis.

Parameters:
NREG, 32, number of architectural integer registers; x0 is never tracked
CNT_W, 32, width of each saturating performance counter

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-low
id_valid  in  1  the ID stage holds a valid instruction
id_rs1  in  5  ID source 1 (0 = unused)
id_rs2  in  5  ID source 2 (0 = unused)
id_rd  in  5  ID destination
id_wen  in  1  the ID instruction writes rd
id_long  in  1  the ID instruction is a load or MUL/DIV (long latency)
id_muldiv  in  1  the ID instruction uses the multi-cycle MUL/DIV unit
mdu_busy  in  1  the MUL/DIV unit is occupied
mem_busy  in  1  the LSU/AXI transaction is not complete; the pipeline must freeze
ex_redirect  in  1  EX resolved a taken branch, jump, ecall or mret
wb_clr  in  1  a long-latency result commits this cycle
wb_rd  in  5  destination of the committing long-latency result
stall_if  out  1  hold the PC and IF/ID
stall_id  out  1  hold ID/EX inputs (hold the ID instruction)
stall_ex  out  1  hold ID/EX and EX/MEM
stall_mem  out  1  hold MEM/WB
flush_id  out  1  invalidate IF/ID
flush_ex  out  1  invalidate ID/EX (inject a bubble)
has_hazard  out  1  decode must drive zero control bundles this cycle
cnt_hazard  out  CNT_W  cycles with has_hazard=1 caused by a data or MDU hazard
cnt_memstall  out  CNT_W  cycles spent in FREEZE or FLUSH_HOLD

Behaviour:
- Reset (rst=0, async): scoreboard all 0, state RUN, counters 0. All stall and flush outputs and has_hazard are 0 while in reset.
- Scoreboard sb[NREG-1:0] is registered.
  - id_fire = id_valid & ~stall_id & ~flush_id.
  - On id_fire & id_wen & id_long & id_rd!=0, set sb[id_rd].
  - On wb_clr & wb_rd!=0, clear sb[wb_rd].
  - If set and clear hit the same register in the same cycle, set wins.
  - sb[0] is always 0.
- Data hazard: dh = id_valid & ((id_rs1!=0 & sb[id_rs1]) | (id_rs2!=0 & sb[id_rs2])). The check uses the registered sb, so a stall releases the cycle after wb_clr. ALU results are fully forwarded and never stall.
- MDU hazard: mh = id_valid & id_muldiv & mdu_busy.
- FSM states: RUN, FREEZE, FLUSH_HOLD.
  - RUN → FREEZE when mem_busy & ~ex_redirect.
  - RUN → FLUSH_HOLD when mem_busy & ex_redirect.
  - FREEZE → FLUSH_HOLD when ex_redirect while frozen.
  - FREEZE → RUN when ~mem_busy.
  - FLUSH_HOLD → RUN when ~mem_busy, asserting flush_id=flush_ex=1 in that exit cycle.
- Outputs in RUN:
  - If ex_redirect: flush_id=flush_ex=1, all stalls 0, has_hazard=0. Redirect beats hazards.
  - Else if dh|mh: stall_if=stall_id=1, flush_ex=1, has_hazard=1, stall_ex=stall_mem=0.
  - Else: all 0.
- Outputs in FREEZE/FLUSH_HOLD: stall_if=stall_id=stall_ex=stall_mem=1; flush_*=0; has_hazard=0. The pending redirect is applied only on the exit cycle.
- All outputs are combinational from state plus inputs. There is no added latency.
- Counters: cnt_hazard increments each RUN cycle with has_hazard=1. cnt_memstall increments each cycle in FREEZE or FLUSH_HOLD. Both saturate at all-ones and never wrap.
- Reset mid-operation: all state is lost immediately. An in-flight long op that commits after reset does not corrupt sb, because its clear hits an already-zero entry.

Decomposition:
- The shared defines header gets the FSM state encodings (2-bit) and the NREG/CNT_W defaults.
- One natural sub-module: ysyx_22050133_scoreboard, holding sb plus the set/clear/lookup logic with two read ports.
- The FSM and counters stay in the top module.

Test Plan:
- Load x5 issued (id_long, rd=5), next instruction reads rs1=5 → has_hazard=1, stall_if=stall_id=1, flush_ex=1 each cycle until wb_clr rd=5. Stall drops the following cycle; cnt_hazard equals the stall length.
- id_muldiv=1 with mdu_busy=1 for 4 cycles → 4 bubble cycles; no stall once mdu_busy=0. An ALU instruction reading an x1 that is not in the scoreboard never stalls.
- mem_busy high for 3 cycles → FREEZE, all four stalls=1, cnt_memstall=3, then RUN with outputs 0.
- ex_redirect coincident with mem_busy (busy for 2 cycles) → FLUSH_HOLD with no flush while busy. The exit cycle has flush_id=flush_ex=1, then RUN.
- Same-cycle wb_clr rd=7 and issue of a load to rd=7 → sb[7] stays 1. A long op writing rd=0 never sets sb[0], and a reader of x0 never stalls.
- Assert rst=0 asynchronously mid-stall → outputs go 0 immediately, the scoreboard is empty, and the counters are 0.

Source files
------------

// File: rtl/ysyx_22050133_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/sequencing controller.
// The FSM state encoding lives here so the top and any checkers agree on it.
package ysyx_22050133_hazard_ctrl_pkg;

  localparam int NREG_DEF  = 32;
  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_FREEZE     = 2'd1,
    ST_FLUSH_HOLD = 2'd2
  } hc_state_e;

endpackage

// File: rtl/ysyx_22050133_hazard_ctrl_scoreboard.sv
// Pending-write scoreboard for long-latency destinations (loads, MUL/DIV).
// One set port (issue), one clear port (commit), two combinational lookup ports.
module ysyx_22050133_scoreboard #(
  parameter int NREG = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en,
  input  logic [4:0] set_idx,
  input  logic       clr_en,
  input  logic [4:0] clr_idx,
  input  logic [4:0] rd_idx1,
  input  logic [4:0] rd_idx2,
  output logic       hit1,
  output logic       hit2
);

  logic [NREG-1:0] sb_q;
  logic [NREG-1:0] sb_d;

  // Clear is applied first so a same-cycle re-issue to the same register wins.
  always_comb begin
    sb_d = sb_q;
    if (clr_en && (clr_idx != 5'd0)) sb_d[clr_idx] = 1'b0;
    if (set_en && (set_idx != 5'd0)) sb_d[set_idx] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sb_q <= '0;
    else      sb_q <= sb_d;
  end

  assign hit1 = (rd_idx1 != 5'd0) & sb_q[rd_idx1];
  assign hit2 = (rd_idx2 != 5'd0) & sb_q[rd_idx2];

endmodule

// File: rtl/ysyx_22050133_hazard_ctrl.sv
// Pipeline sequencing controller: data/MDU hazard bubbles, memory freeze,
// redirect serialisation against memory back-pressure, saturating stall counters.
module ysyx_22050133_hazard_ctrl
  import ysyx_22050133_hazard_ctrl_pkg::*;
#(
  parameter int NREG  = NREG_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_wen,
  input  logic             id_long,
  input  logic             id_muldiv,
  input  logic             mdu_busy,
  input  logic             mem_busy,
  input  logic             ex_redirect,
  input  logic             wb_clr,
  input  logic [4:0]       wb_rd,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             has_hazard,
  output logic [CNT_W-1:0] cnt_hazard,
  output logic [CNT_W-1:0] cnt_memstall
);

  hc_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_hazard_q, cnt_hazard_d;
  logic [CNT_W-1:0] cnt_memstall_q, cnt_memstall_d;
  logic             hit1, hit2, dh, mh, id_fire;

  // Handshake: ID issues (id_fire) only when valid and neither held nor squashed.
  assign id_fire = id_valid & ~stall_id & ~flush_id;

  ysyx_22050133_scoreboard #(.NREG(NREG)) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (id_fire & id_wen & id_long),
    .set_idx (id_rd),
    .clr_en  (wb_clr),
    .clr_idx (wb_rd),
    .rd_idx1 (id_rs1),
    .rd_idx2 (id_rs2),
    .hit1    (hit1),
    .hit2    (hit2)
  );

  assign dh = id_valid & (hit1 | hit2);
  assign mh = id_valid & id_muldiv & mdu_busy;

  always_comb begin
    state_d    = state_q;
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    stall_ex   = 1'b0;
    stall_mem  = 1'b0;
    flush_id   = 1'b0;
    flush_ex   = 1'b0;
    has_hazard = 1'b0;
    // Outputs are forced quiet while reset is asserted, independent of inputs.
    if (rst) begin
      case (state_q)
        ST_RUN: begin
          if (mem_busy) state_d = ex_redirect ? ST_FLUSH_HOLD : ST_FREEZE;
          if (ex_redirect) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
          end else if (dh | mh) begin
            stall_if   = 1'b1;
            stall_id   = 1'b1;
            flush_ex   = 1'b1;
            has_hazard = 1'b1;
          end
        end
        ST_FREEZE: begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          stall_ex  = 1'b1;
          stall_mem = 1'b1;
          if (!mem_busy)        state_d = ST_RUN;
          else if (ex_redirect) state_d = ST_FLUSH_HOLD;
        end
        ST_FLUSH_HOLD: begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          stall_ex  = 1'b1;
          stall_mem = 1'b1;
          if (!mem_busy) begin
            state_d  = ST_RUN;
            flush_id = 1'b1;
            flush_ex = 1'b1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    cnt_hazard_d   = cnt_hazard_q;
    cnt_memstall_d = cnt_memstall_q;
    if ((state_q == ST_RUN) && has_hazard && !(&cnt_hazard_q))
      cnt_hazard_d = cnt_hazard_q + CNT_W'(1);
    if ((state_q != ST_RUN) && !(&cnt_memstall_q))
      cnt_memstall_d = cnt_memstall_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_RUN;
      cnt_hazard_q   <= '0;
      cnt_memstall_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_hazard_q   <= cnt_hazard_d;
      cnt_memstall_q <= cnt_memstall_d;
    end
  end

  assign cnt_hazard   = cnt_hazard_q;
  assign cnt_memstall = cnt_memstall_q;

endmodule

// File: tb/tb_ysyx_22050133_hazard_ctrl.sv
// Bench for the hazard controller: single-cycle vector table in RUN plus
// hand-written multi-cycle sequences, with an expected-output queue.
module tb_ysyx_22050133_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_wen, id_long, id_muldiv, mdu_busy, mem_busy;
  logic        ex_redirect, wb_clr;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
  logic        stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, has_hazard;
  logic [31:0] cnt_hazard, cnt_memstall;

  ysyx_22050133_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_wen(id_wen), .id_long(id_long), .id_muldiv(id_muldiv),
    .mdu_busy(mdu_busy), .mem_busy(mem_busy), .ex_redirect(ex_redirect),
    .wb_clr(wb_clr), .wb_rd(wb_rd),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush_id(flush_id), .flush_ex(flush_ex), .has_hazard(has_hazard),
    .cnt_hazard(cnt_hazard), .cnt_memstall(cnt_memstall)
  );

  // clock/reset
  always #5 clk = ~clk;

  // output vector order: {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, has_hazard}
  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_HAZ  = 7'b1100011;
  localparam logic [6:0] O_RDR  = 7'b0000110;
  localparam logic [6:0] O_FRZ  = 7'b1111000;
  localparam logic [6:0] M_ALL  = 7'b1111111;

  int checks = 0;
  int errors = 0;
  int exp_hz = 0;
  int exp_ms = 0;

  logic [6:0] exp_q[$];
  logic [6:0] msk_q[$];
  string      name_q[$];

  typedef struct {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       muldiv;
    logic       mdu_busy;
    logic       redir;
    logic [6:0] exp;
  } vec_t;
  vec_t vecs[8];

  function automatic logic [6:0] outs();
    return {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, has_hazard};
  endfunction

  // driver tasks
  task automatic drv(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic wen, input logic lng,
                     input logic md, input logic mb, input logic memb, input logic rdr,
                     input logic clr, input logic [4:0] crd);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_wen = wen; id_long = lng;
    id_muldiv = md; mdu_busy = mb; mem_busy = memb; ex_redirect = rdr;
    wb_clr = clr; wb_rd = crd;
  endtask

  task automatic expect_out(input logic [6:0] e, input logic [6:0] m, input string nm);
    exp_q.push_back(e);
    msk_q.push_back(m);
    name_q.push_back(nm);
    if (rst && m[0] && e[0]) exp_hz++;
  endtask

  // scoreboard: pop the oldest expectation and compare against live outputs
  task automatic sample();
    logic [6:0] e, m, g;
    string nm;
    e = exp_q.pop_front();
    m = msk_q.pop_front();
    nm = name_q.pop_front();
    g = outs();
    checks++;
    if (((g ^ e) & m) != 7'd0) begin
      errors++;
      $display("FAIL %s: outputs got %b expected %b (mask %b)", nm, g, e, m);
    end
  endtask

  task automatic chk(input logic [6:0] e, input logic [6:0] m, input string nm);
    expect_out(e, m, nm);
    #1;
    sample();
    @(negedge clk);
  endtask

  task automatic check_val(input string nm, input logic [31:0] got, input logic [31:0] e);
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, e);
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_NONE};
    vecs[1] = '{1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, O_NONE};
    vecs[2] = '{1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b0, O_HAZ};
    vecs[3] = '{1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, O_NONE};
    vecs[4] = '{1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, O_NONE};
    vecs[5] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, O_RDR};
    vecs[6] = '{1'b1, 5'd3, 5'd0, 1'b1, 1'b1, 1'b1, O_RDR};
    vecs[7] = '{1'b1, 5'd1, 5'd1, 1'b0, 1'b1, 1'b0, O_NONE};

    // reset with hazard-provoking inputs: outputs must stay quiet
    rst = 1'b0;
    drv(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0);
    @(negedge clk);
    expect_out(O_NONE, M_ALL, "reset_outputs");
    #1;
    sample();
    check_val("reset_cnt_hazard", cnt_hazard, 32'd0);
    check_val("reset_cnt_memstall", cnt_memstall, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // table-driven single-cycle vectors in RUN with an empty scoreboard
    for (int i = 0; i < 8; i++) begin
      drv(vecs[i].valid, vecs[i].rs1, vecs[i].rs2, 5'd0, 1'b0, 1'b0,
          vecs[i].muldiv, vecs[i].mdu_busy, 1'b0, vecs[i].redir, 1'b0, 5'd0);
      chk(vecs[i].exp, M_ALL, $sformatf("vec%0d", i));
    end
    check_val("table_cnt_hazard", cnt_hazard, exp_hz);

    // load x5, dependent reader stalls until the commit, releases next cycle
    drv(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk(O_NONE, M_ALL, "load_x5_issue");
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      chk(O_HAZ, M_ALL, $sformatf("raw_x5_stall%0d", i));
    end
    drv(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5);
    chk(O_HAZ, M_ALL, "raw_x5_clr_cycle");
    drv(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk(O_NONE, M_ALL, "raw_x5_release");
    check_val("raw_cnt_hazard", cnt_hazard, exp_hz);

    // MDU busy for 4 cycles
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
      chk(O_HAZ, M_ALL, $sformatf("mdu_stall%0d", i));
    end
    drv(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk(O_NONE, M_ALL, "mdu_release");
    check_val("mdu_cnt_hazard", cnt_hazard, exp_hz);

    // mem_busy for 3 cycles: RUN, then FREEZE until the cycle after busy drops
    drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    chk(O_NONE, M_ALL, "memb_enter");
    for (int i = 0; i < 2; i++) begin
      chk(O_FRZ, M_ALL, $sformatf("memb_freeze%0d", i));
    end
    mem_busy = 1'b0;
    chk(O_FRZ, M_ALL, "memb_freeze_exit");
    chk(O_NONE, M_ALL, "memb_run");
    exp_ms += 3;
    check_val("memb_cnt_memstall", cnt_memstall, exp_ms);

    // redirect coincident with mem_busy: hold without flushing, flush on exit
    drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0);
    chk(O_NONE, 7'b1111001, "fh_enter");
    chk(O_FRZ, M_ALL, "fh_hold");
    mem_busy = 1'b0;
    chk(7'b0000110, 7'b0000110, "fh_exit_flush");
    ex_redirect = 1'b0;
    chk(O_NONE, M_ALL, "fh_run");
    exp_ms += 2;
    check_val("fh_cnt_memstall", cnt_memstall, exp_ms);

    // same-cycle clear and re-issue of x7: set wins
    drv(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk(O_NONE, M_ALL, "x7_issue");
    drv(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7);
    chk(O_NONE, M_ALL, "x7_reissue_clr");
    drv(1'b1, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk(O_HAZ, M_ALL, "x7_still_pending");
    drv(1'b1, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7);
    chk(O_HAZ, M_ALL, "x7_clr_cycle");
    drv(1'b1, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk(O_NONE, M_ALL, "x7_release");

    // x0 is never tracked
    drv(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk(O_NONE, M_ALL, "x0_issue");
    drv(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk(O_NONE, M_ALL, "x0_reader");
    check_val("seq_cnt_hazard", cnt_hazard, exp_hz);

    // asynchronous reset in the middle of a data-hazard stall
    drv(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk(O_NONE, M_ALL, "x9_issue");
    drv(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    expect_out(O_HAZ, M_ALL, "x9_stall");
    #1;
    sample();
    #2;
    rst = 1'b0;
    expect_out(O_NONE, M_ALL, "async_reset_outputs");
    #1;
    sample();
    exp_hz = 0;
    exp_ms = 0;
    check_val("async_reset_cnt_hazard", cnt_hazard, 32'd0);
    check_val("async_reset_cnt_memstall", cnt_memstall, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    chk(O_NONE, M_ALL, "x9_after_reset");
    drv(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9);
    chk(O_NONE, M_ALL, "x9_late_commit");
    drv(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk(O_NONE, M_ALL, "x9_post_commit");
    check_val("final_cnt_hazard", cnt_hazard, exp_hz);
    check_val("final_cnt_memstall", cnt_memstall, exp_ms);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
